alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
Execution stage directly downstream of the instruction controller. It consumes enable/opcode/a/b, performs the arithmetic operation and returns a one-cycle done pulse that lets the controller advance pc. ADD/SUB complete in one compute cycle. MUL/DIV are iterative, taking 8 compute cycles. The result is held in a register for the display/output logic.

Parameters:
WIDTH, 16, result width; must be >= 16 (2x operand width).
OPW, 8, operand width of a and b; fixed by the instruction format.

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
enable  input  1  controller request; held high through EXECUTE until done is seen
opcode  input  4  operation code latched by the controller
a  input  8  operand A
b  input  8  operand B
done  output  1  one-cycle completion pulse (registered)
busy  output  1  high while state != IDLE
result  output  WIDTH  last completed result, held until the next completion
div_by_zero  output  1  sticky per-result flag; updated with result
last_op  output  4  opcode that produced the current result

Behaviour:
- Opcodes: 0001 ADD, 0010 SUB, 0011 MUL, 1011 DIV, 1111 HALT. All other codes are invalid.
- Reset (sync, on posedge clk with reset=1) has priority over everything, including mid-operation. Reset values:
  - state=IDLE, done=0, busy=0, result=0, div_by_zero=0, last_op=0, armed=1, counter=0.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - If enable && armed && opcode in {ADD,SUB,MUL,DIV}: capture a, b and opcode into internal registers, clear counter, go to CALC.
  - enable with HALT or an invalid opcode (the controller pulses enable for one cycle in DECODE for these): ignored. No state change, no done, result untouched.
- CALC:
  - ADD/SUB: one cycle. Write result, go to FINISH.
  - MUL/DIV: counter runs 0..7. On counter==7, write result and go to FINISH.
- FINISH: done=1 for exactly this cycle; armed<=0; go to IDLE.
- armed is set again on any cycle in which enable=0. This prevents a restart if enable is still high in the cycle after done.
- Latency: enable first sampled high at edge t.
  - ADD/SUB: done high in cycle t+2.
  - MUL/DIV: done high in cycle t+9.
- Input changes on a/b/opcode during CALC have no effect; the captured copies are used.
- Arithmetic (operands zero-extended to WIDTH):
  - ADD: result = a + b, 9 significant bits.
  - SUB: result = (a - b) mod 2^WIDTH. Example: 3-5 = 16'hFFFE.
  - MUL: shift-add, 1 bit per cycle, LSB first; result = a*b, exact in 16 bits.
  - DIV: restoring division, 1 quotient bit per cycle, MSB first; result = {remainder[7:0], quotient[7:0]}.
  - DIV with b=0: still 8 cycles; quotient=8'hFF, remainder=a, div_by_zero=1.
  - Every other completion clears div_by_zero.
- result, last_op and div_by_zero change only on the edge that enters FINISH.

Decomposition:
- Shared package (alu_pkg):
  - Opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_HALT.
  - is_arith() helper function.
  - FSM state enum exec_state_t.
  - The controller's valid-opcode check also moves to this package.
- One sub-module, iter_muldiv, holds the 8-step shift-add/restoring-divide datapath.
  - Ports: start, op_div, a, b, step, product/quotient/remainder outputs.
  - alu_exec keeps the FSM, counter, armed flag and result registers.

Test Plan:
- Reset, then enable=1, opcode=0001, a=8'd200, b=8'd100 -> done pulse in cycle t+2, result=16'd300, busy high t+1..t+2.
- SUB a=3, b=5 -> result=16'hFFFE at done; then MUL a=8'hFF, b=8'hFF -> done at t+9, result=16'hFE01.
- DIV a=8'd100, b=8'd7 -> done at t+9, result=16'h020E (rem 2, quot 14), div_by_zero=0. Then DIV a=9, b=0 -> result=16'h09FF, div_by_zero=1.
- One-cycle enable with opcode=1111, then with opcode=0101 -> no done, busy stays 0, result unchanged from the prior value.
- Enable held high for 3 cycles after done -> no second operation until enable drops for 1 cycle. A new ADD issued after that completes normally.
- Assert reset at counter=4 of a MUL -> next cycle state IDLE, result=0, done=0. A subsequent ADD 1+1 gives result=2 at t+2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and opcode classification helpers for the execution stage
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} exec_state_t;
  function automatic logic is_arith(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic logic is_valid(input logic [3:0] op);
    return is_arith(op) || op == OP_HALT;
  endfunction
endpackage

// File: rtl/alu_exec_iter_muldiv.sv
// iter_muldiv: 8-step shift-add multiplier / restoring divider; outputs show the value after the current step
module iter_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        op_div_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic        step_i,
  output logic [15:0] product_o,
  output logic [7:0]  quotient_o,
  output logic [7:0]  remainder_o
);
  logic [7:0]  x_q, x_d;
  logic [15:0] y_q, y_d, acc_q, acc_d, mul_acc;
  logic [8:0]  r;
  logic [7:0]  rn;
  logic        ge;
  // x: multiplier / dividend-then-quotient, y: multiplicand / divisor, acc: product / partial remainder
  always_comb begin
    mul_acc = acc_q + (x_q[0] ? y_q : 16'd0);
    r = {acc_q[7:0], x_q[7]};
    ge = r >= {1'b0, y_q[7:0]};
    rn = ge ? 8'(r - {1'b0, y_q[7:0]}) : r[7:0];
    x_d = start_i ? a_i : step_i ? (op_div_i ? {x_q[6:0], ge} : {1'b0, x_q[7:1]}) : x_q;
    y_d = start_i ? {8'd0, b_i} : (step_i && !op_div_i) ? {y_q[14:0], 1'b0} : y_q;
    acc_d = start_i ? 16'd0 : step_i ? (op_div_i ? {8'd0, rn} : mul_acc) : acc_q;
    product_o = mul_acc;
    quotient_o = {x_q[6:0], ge};
    remainder_o = rn;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      acc_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execution stage FSM; single-cycle ADD/SUB, 8-cycle MUL/DIV, registered done pulse and held result
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       opcode,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [3:0]       last_op
);
  exec_state_t      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             armed_q, armed_d, launch, iter, fin;
  logic [3:0]       op_q, op_d, last_op_q, last_op_d;
  logic [OPW-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d, calc;
  logic             dbz_q, dbz_d;
  logic [15:0]      prod;
  logic [7:0]       quot, rem;
  iter_muldiv u_iter (
    .clk(clk), .reset(reset), .start_i(launch), .op_div_i(op_q == OP_DIV),
    .a_i(a), .b_i(b), .step_i(state_q == CALC && iter),
    .product_o(prod), .quotient_o(quot), .remainder_o(rem)
  );
  always_comb begin
    launch = state_q == IDLE && enable && armed_q && is_arith(opcode);
    iter = op_q == OP_MUL || op_q == OP_DIV;
    fin = state_q == CALC && (!iter || cnt_q == 3'd7);
    state_d = launch ? CALC : fin ? FINISH : state_q == FINISH ? IDLE : state_q;
    cnt_d = launch ? 3'd0 : state_q == CALC ? cnt_q + 3'd1 : cnt_q;
    // a low enable re-arms even in FINISH, so a controller that drops enable early can issue again
    armed_d = !enable ? 1'b1 : state_q == FINISH ? 1'b0 : armed_q;
    op_d = launch ? opcode : op_q;
    a_d = launch ? a : a_q;
    b_d = launch ? b : b_q;
    calc = op_q == OP_ADD ? WIDTH'(a_q) + WIDTH'(b_q)
         : op_q == OP_SUB ? WIDTH'(a_q) - WIDTH'(b_q)
         : op_q == OP_MUL ? WIDTH'(prod)
         : WIDTH'({rem, quot});
    result_d = fin ? calc : result_q;
    last_op_d = fin ? op_q : last_op_q;
    dbz_d = fin ? (op_q == OP_DIV && b_q == '0) : dbz_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      armed_q <= 1'b1;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      last_op_q <= '0;
      dbz_q <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      last_op_q <= last_op_d;
      dbz_q <= dbz_d;
      done <= state_d == FINISH;
      busy <= state_d != IDLE;
    end
  end
  assign result = result_q;
  assign last_op = last_op_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors with hand-computed results for alu_exec
module tb_alu_exec;
  logic        clk = 1'b0;
  logic        reset, enable, done, busy, div_by_zero;
  logic [3:0]  opcode, last_op;
  logic [7:0]  a, b;
  logic [15:0] result;
  int          n = 0, errs = 0;

  alu_exec #(.WIDTH(16), .OPW(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .a(a), .b(b),
    .done(done), .busy(busy), .result(result), .div_by_zero(div_by_zero), .last_op(last_op)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issues one op, scrambles the inputs during CALC, and waits (bounded) for done; enable is left high
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        input int lat, input logic [15:0] res, input logic dz);
    int cnt;
    opcode = op; a = x; b = y; enable = 1'b1;
    tick;
    chk({tag, " busy"}, busy, 1);
    a = x ^ 8'h5A; b = y ^ 8'hA5; opcode = 4'b0101;
    cnt = 1;
    while (!done && cnt < 20) begin
      tick;
      cnt++;
    end
    chk({tag, " latency"}, cnt, lat);
    chk({tag, " result"}, result, res);
    chk({tag, " dbz"}, div_by_zero, dz);
    chk({tag, " last_op"}, last_op, op);
  endtask

  task automatic release_en(input string tag);
    enable = 1'b0;
    tick;
    chk({tag, " done drop"}, done, 0);
    chk({tag, " busy drop"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; opcode = 4'd0; a = 8'd0; b = 8'd0;
    tick;
    tick;
    reset = 1'b0;
    chk("rst result", result, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst dbz", div_by_zero, 0);
    chk("rst last_op", last_op, 0);

    run_op("add", 4'b0001, 8'd200, 8'd100, 2, 16'd300, 1'b0);
    release_en("add");
    run_op("sub", 4'b0010, 8'd3, 8'd5, 2, 16'hFFFE, 1'b0);
    release_en("sub");
    run_op("mul", 4'b0011, 8'hFF, 8'hFF, 9, 16'hFE01, 1'b0);
    release_en("mul");
    run_op("div", 4'b1011, 8'd100, 8'd7, 9, 16'h020E, 1'b0);
    release_en("div");
    run_op("div0", 4'b1011, 8'd9, 8'd0, 9, 16'h09FF, 1'b1);
    release_en("div0");

    opcode = 4'b1111; a = 8'd1; b = 8'd1; enable = 1'b1;
    tick;
    enable = 1'b0;
    chk("halt busy", busy, 0);
    tick;
    chk("halt done", done, 0);
    opcode = 4'b0101; enable = 1'b1;
    tick;
    enable = 1'b0;
    chk("inv busy", busy, 0);
    tick;
    chk("inv done", done, 0);
    chk("inv result", result, 16'h09FF);
    chk("inv dbz", div_by_zero, 1);
    chk("inv last_op", last_op, 4'b1011);

    run_op("hold", 4'b0001, 8'd10, 8'd20, 2, 16'd30, 1'b0);
    opcode = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold done", done, 0);
      chk("hold busy", busy, 0);
    end
    release_en("hold");
    run_op("rearm", 4'b0001, 8'd5, 8'd6, 2, 16'd11, 1'b0);
    release_en("rearm");

    opcode = 4'b0011; a = 8'd7; b = 8'd9; enable = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    chk("mid busy", busy, 1);
    reset = 1'b1; enable = 1'b0;
    tick;
    reset = 1'b0;
    chk("mrst busy", busy, 0);
    chk("mrst done", done, 0);
    chk("mrst result", result, 0);
    chk("mrst last_op", last_op, 0);
    tick;
    chk("mrst idle", busy, 0);
    run_op("post", 4'b0001, 8'd1, 8'd1, 2, 16'd2, 1'b0);
    release_en("post");

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
